// File: rtl/alu_chk_pkg.sv
// Types and golden model for the ALU response checker.
//   exp_t       : expected response {alu, carry, zero}
//   chk_state_e : checker run state
//   alu_golden  : combinational reference model of one ALU request
package alu_chk_pkg;
  import macro_pkg::*;

  localparam int ALU_W = 4;

  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic             carry;
    logic             zero;
  } exp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  // All arithmetic is done one bit wider than the operands so the top bit
  // is the carry-out (ADD) or the borrow (SUB, negative result in two's complement).
  function automatic exp_t alu_golden(input logic [3:0]       ctl,
                                      input logic [ALU_W-1:0] a,
                                      input logic [ALU_W-1:0] b,
                                      input logic             cin);
    logic [ALU_W:0] r;
    exp_t           e;
    r = '0;
    case (ctl)
      OP_ADD:   r = {1'b0, a} + {1'b0, b} + {{ALU_W{1'b0}}, cin};
      OP_SUB:   r = {1'b0, a} - {1'b0, b} - {{ALU_W{1'b0}}, cin};
      OP_AND:   r = {1'b0, a & b};
      OP_OR:    r = {1'b0, a | b};
      OP_XOR:   r = {1'b0, a ^ b};
      OP_NOT:   r = {1'b0, ~a};
      OP_SHL:   r = {a, 1'b0};
      OP_SHR:   r = {a[0], 1'b0, a[ALU_W-1:1]};
      OP_PASSA: r = {1'b0, a};
      OP_PASSB: r = {1'b0, b};
      default:  r = '0;
    endcase
    e.alu   = r[ALU_W-1:0];
    e.carry = r[ALU_W];
    e.zero  = (r[ALU_W-1:0] == '0);
    return e;
  endfunction

endpackage

// File: rtl/macro_pkg.sv
// Shared ALU opcode definitions used by the stimulus driver and the checker.
// Operation table (W = operand width, result is {carry, alu}):
//   OP_ADD   : a + b + cin, carry = carry-out
//   OP_SUB   : a - b - cin, carry = borrow
//   OP_AND   : a & b,       carry = 0
//   OP_OR    : a | b,       carry = 0
//   OP_XOR   : a ^ b,       carry = 0
//   OP_NOT   : ~a,          carry = 0
//   OP_SHL   : a << 1,      carry = a[W-1]
//   OP_SHR   : a >> 1,      carry = a[0]
//   OP_PASSA : a,           carry = 0
//   OP_PASSB : b,           carry = 0
//   other    : result 0,    carry = 0
package macro_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOT   = 4'h5,
    OP_SHL   = 4'h6,
    OP_SHR   = 4'h7,
    OP_PASSA = 4'h8,
    OP_PASSB = 4'h9
  } opcode_e;

endpackage

// File: rtl/alu_exp_fifo.sv
// Expected-response FIFO: DEPTH x exp_t, synchronous, first-word fall-through
// read (rdata_o is always the head entry).
//   clk, reset  : clock, synchronous active-high reset
//   flush_i     : empty the FIFO on the next edge
//   push_i      : write wdata_i; honoured when not full, or when full with a pop
//   pop_i       : discard the head; ignored when empty
//   rdata_o     : head entry (valid when !empty_o)
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
module alu_exp_fifo
  import alu_chk_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  input  logic push_i,
  input  logic pop_i,
  input  exp_t wdata_i,
  output exp_t rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  exp_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot in the same edge, so a full FIFO still accepts a push.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_i);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_resp_checker.sv
// In-order ALU response checker. Snoops the ALU request bus, queues a golden
// {alu,carry,zero} per request, and compares each DUT response beat against
// the oldest queued entry.
//   clk, reset        : clock, synchronous active-high reset
//   start / stop      : pulses; start clears everything and enters RUN,
//                       stop stops accepting requests and drains the queue
//   valid_in, ctl, a, b, cin : snooped request bus
//   valid_out, alu, carry, zero : DUT response
//   correct_count / incorrect_count : saturating tallies
//   mismatch          : one-cycle pulse the cycle after a bad beat
//   busy / finished   : state is RUN or DRAIN / state is DONE
//   ovf_err, unexp_err, timeout_err : sticky error flags
//   state_dbg         : current checker state (chk_state_e encoding)
//
// Strobe semantics: both buses are observe-only with no back-pressure. A
// request is a single cycle with valid_in=1 and a response is a single cycle
// with valid_out=1; each strobed cycle is exactly one transaction.
module alu_resp_checker
  import alu_chk_pkg::*;
#(
  parameter int WIDTH   = ALU_W,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             valid_in,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             valid_out,
  input  logic [WIDTH-1:0] alu,
  input  logic             carry,
  input  logic             zero,
  output logic [CNT_W-1:0] correct_count,
  output logic [CNT_W-1:0] incorrect_count,
  output logic             mismatch,
  output logic             busy,
  output logic             finished,
  output logic             ovf_err,
  output logic             unexp_err,
  output logic             timeout_err,
  output logic [1:0]       state_dbg
);

  localparam int TW = $clog2(TIMEOUT + 1);

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] correct_q, incorrect_q;
  logic             mismatch_q, ovf_q, unexp_q, timeout_q;
  logic [TW-1:0]    to_cnt_q;
  logic [TW-1:0]    to_inc;

  logic active, push_req, push_ok, cmp, unexp, ovf, match, timeout_hit;
  logic fifo_full, fifo_empty;
  exp_t golden, head, dut_rsp;

  assign golden  = alu_golden(ctl, a, b, cin);
  assign dut_rsp = '{alu: alu, carry: carry, zero: zero};

  alu_exp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (start),
    .push_i  (push_req),
    .pop_i   (cmp),
    .wdata_i (golden),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The start cycle only flushes; nothing is pushed or compared in it.
  assign active   = !start && ((state_q == RUN) || (state_q == DRAIN));
  assign push_req = !start && !stop && (state_q == RUN) && valid_in;
  assign cmp      = active && valid_out && !fifo_empty;
  assign unexp    = active && valid_out && fifo_empty;
  assign push_ok  = push_req && (!fifo_full || cmp);
  assign ovf      = push_req && fifo_full && !cmp;
  assign match    = (dut_rsp == head);

  assign to_inc      = to_cnt_q + 1'b1;
  assign timeout_hit = active && !fifo_empty && !push_ok && !cmp && (to_inc == TW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (timeout_hit) state_d = DONE;
                 else if (stop)   state_d = DRAIN;
        DRAIN:   if (timeout_hit || fifo_empty) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      correct_q   <= '0;
      incorrect_q <= '0;
      mismatch_q  <= 1'b0;
      ovf_q       <= 1'b0;
      unexp_q     <= 1'b0;
      timeout_q   <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      mismatch_q <= cmp && !match;
      if (cmp && match && (correct_q != '1))    correct_q   <= correct_q + 1'b1;
      if (cmp && !match && (incorrect_q != '1)) incorrect_q <= incorrect_q + 1'b1;
      if (ovf)         ovf_q     <= 1'b1;
      if (unexp)       unexp_q   <= 1'b1;
      if (timeout_hit) timeout_q <= 1'b1;
      // Idle time is only meaningful while something is outstanding.
      if (!active || fifo_empty || push_ok || cmp) to_cnt_q <= '0;
      else                                         to_cnt_q <= to_inc;
    end
  end

  assign correct_count   = correct_q;
  assign incorrect_count = incorrect_q;
  assign mismatch        = mismatch_q;
  assign ovf_err         = ovf_q;
  assign unexp_err       = unexp_q;
  assign timeout_err     = timeout_q;
  assign busy            = (state_q == RUN) || (state_q == DRAIN);
  assign finished        = (state_q == DONE);
  assign state_dbg       = state_q;

endmodule
